// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Handshake bundle between instruction fetch, the fetch queue
//                and decode.
//                  flush      - discard every stored entry
//                  enq_valid  - fetch offers enq_data this cycle
//                  enq_data   - entry to store (instr | pc | next pc)
//                  enq_ready  - queue can accept an entry this cycle
//                  deq_valid  - head entry is present on deq_data
//                  deq_data   - head entry, all zeros when the queue is empty
//                  deq_ready  - decode consumes the head this cycle
//                  count      - number of stored entries
//                master : fetch/decode side, slave : the queue itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
);
  logic                       flush;
  logic                       enq_valid;
  logic [DATA_W-1:0]          enq_data;
  logic                       enq_ready;
  logic                       deq_valid;
  logic [DATA_W-1:0]          deq_data;
  logic                       deq_ready;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output flush, enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count
  );

  modport slave (
    input  flush, enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : First-word-fall-through queue between fetch and decode.
//                An empty queue presents an all-zero (NOP) head.
//  Ports       : CLK  - rising-edge clock
//                nRST - asynchronous active-low reset
//                bus  - fetch_queue_if.slave handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
) (
  input  wire logic     CLK,
  input  wire logic     nRST,
  fetch_queue_if.slave  bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);

  // Handshakes qualified with state-only ready/valid; flush overrides both.
  assign w_enq = bus.enq_valid & ~w_full  & ~bus.flush;
  assign w_deq = bus.deq_ready & ~w_empty & ~bus.flush;

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_mem[r_wptr] <= bus.enq_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap to 0 for free.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.enq_ready = ~w_full;
  assign bus.deq_valid = ~w_empty;
  assign bus.deq_data  = w_empty ? '0 : r_mem[r_rptr];
  assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue (DEPTH=4,
//                DATA_W=96).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  logic CLK;
  logic nRST;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [95:0] V_A = 96'hAAAA0001_00001000_00001004;
  localparam logic [95:0] V_B = 96'hBBBB0002_00001004_00001008;
  localparam logic [95:0] V_C = 96'hCCCC0003_00001008_0000100C;
  localparam logic [95:0] V_D = 96'hDDDD0004_0000100C_00001010;
  localparam logic [95:0] V_E = 96'hEEEE0005_00001010_00001014;
  localparam logic [95:0] V_F = 96'hF00F0006_00002000_00002004;
  localparam logic [95:0] V_G = 96'h12340007_00003000_00003004;
  localparam logic [95:0] V_H = 96'h56780008_00003004_00003008;
  localparam logic [95:0] V_X = 96'h9ABC0009_00004000_00004004;

  fetch_queue_if #(.DATA_W(96), .DEPTH(4)) bus ();

  fetch_queue #(.DATA_W(96), .DEPTH(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [95:0] vec [4];
  logic [95:0] sv;

  initial begin
    vec = '{V_A, V_B, V_C, V_D};
    nRST          = 1'b0;
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_data  = '0;
    bus.deq_ready = 1'b0;

    // Reset values before any clock edge.
    #1;
    chk("rst_count", 96'(bus.count), 96'd0);
    chk("rst_dvalid", 96'(bus.deq_valid), 96'd0);
    chk("rst_ddata", bus.deq_data, 96'd0);
    chk("rst_eready", 96'(bus.enq_ready), 96'd1);
    @(negedge CLK);
    nRST = 1'b1;

    // Fill A..D; head falls through one cycle after the first write.
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.enq_data = vec[i];
      step();
      chk("fill_count", 96'(bus.count), 96'(i + 1));
      chk("fill_head", bus.deq_data, V_A);
    end
    chk("full_eready", 96'(bus.enq_ready), 96'd0);

    // Stall holds state.
    bus.enq_valid = 1'b0;
    step();
    chk("stall_count", 96'(bus.count), 96'd4);
    chk("stall_head", bus.deq_data, V_A);

    // Drain in order.
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", bus.deq_data, vec[i]);
      step();
    end
    chk("drain_count", 96'(bus.count), 96'd0);
    chk("drain_dvalid", 96'(bus.deq_valid), 96'd0);
    chk("drain_ddata", bus.deq_data, 96'd0);

    // Full with simultaneous enqueue/dequeue: E rejected.
    bus.deq_ready = 1'b0;
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.enq_data = vec[i];
      step();
    end
    chk("full2_count", 96'(bus.count), 96'd4);
    bus.enq_data  = V_E;
    bus.deq_ready = 1'b1;
    step();
    chk("fullrw_count", 96'(bus.count), 96'd3);
    chk("fullrw_head", bus.deq_data, V_B);
    bus.enq_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("fullrw_drain", bus.deq_data, vec[i]);
      step();
    end
    chk("fullrw_empty", bus.deq_data, 96'd0);
    chk("fullrw_cnt0", 96'(bus.count), 96'd0);

    // Underflow: deq_ready while empty.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("uflow_count", 96'(bus.count), 96'd0);
      chk("uflow_dvalid", 96'(bus.deq_valid), 96'd0);
      chk("uflow_ddata", bus.deq_data, 96'd0);
    end

    // Steady stream of 10 entries, pointers wrap twice.
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sv = {32'hCAFE0000 + 32'(i), 32'h00008000 + 32'(4 * i), 32'h00008004 + 32'(4 * i)};
      bus.enq_data = sv;
      step();
      chk("stream_count", 96'(bus.count), 96'd1);
      chk("stream_head", bus.deq_data, sv);
    end
    bus.enq_valid = 1'b0;
    step();
    chk("stream_end", 96'(bus.count), 96'd0);

    // Flush collision at count=3.
    bus.deq_ready = 1'b0;
    bus.enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.enq_data = vec[i];
      step();
    end
    chk("pre_flush_cnt", 96'(bus.count), 96'd3);
    bus.flush     = 1'b1;
    bus.enq_data  = V_E;
    bus.deq_ready = 1'b1;
    step();
    chk("flush_count", 96'(bus.count), 96'd0);
    chk("flush_dvalid", 96'(bus.deq_valid), 96'd0);
    chk("flush_ddata", bus.deq_data, 96'd0);
    bus.flush     = 1'b0;
    bus.deq_ready = 1'b0;
    bus.enq_data  = V_F;
    step();
    chk("post_flush_head", bus.deq_data, V_F);
    chk("post_flush_cnt", 96'(bus.count), 96'd1);
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b1;
    step();
    chk("post_flush_drain", 96'(bus.count), 96'd0);

    // Mid-operation asynchronous reset at count=2.
    bus.deq_ready = 1'b0;
    bus.enq_valid = 1'b1;
    bus.enq_data  = V_G;
    step();
    bus.enq_data  = V_H;
    step();
    chk("pre_rst_count", 96'(bus.count), 96'd2);
    bus.enq_valid = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_count", 96'(bus.count), 96'd0);
    chk("arst_dvalid", 96'(bus.deq_valid), 96'd0);
    chk("arst_ddata", bus.deq_data, 96'd0);
    chk("arst_eready", 96'(bus.enq_ready), 96'd1);
    step();
    nRST          = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_data  = V_X;
    step();
    chk("post_rst_head", bus.deq_data, V_X);
    chk("post_rst_count", 96'(bus.count), 96'd1);
    bus.enq_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_W, default 96, SHALL set the entry width (instruction 32 + normal PC 32 + next PC 32).
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count; legal values are powers of two, 2 through 64.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with port names CLK and nRST.
REQ-004 Port CLK, input, width 1: rising-edge clock.
REQ-005 Port nRST, input, width 1: asynchronous active-low reset.
REQ-006 Port flush, input, width 1: discards all stored entries.
REQ-007 Port enq_valid, input, width 1: fetch offers enq_data this cycle.
REQ-008 Port enq_data, input, width DATA_W: entry written on enqueue.
REQ-009 Port enq_ready, output, width 1: the queue accepts an entry this cycle.
REQ-010 Port deq_valid, output, width 1: the head entry is present on deq_data.
REQ-011 Port deq_data, output, width DATA_W: the head entry.
REQ-012 Port deq_ready, input, width 1: decode consumes the head this cycle.
REQ-013 Port count, output, width $clog2(DEPTH+1): number of stored entries.

Function
REQ-014 Enqueue SHALL occur at a rising edge when enq_valid=1, enq_ready=1 and flush=0.
REQ-015 Dequeue SHALL occur at a rising edge when deq_valid=1, deq_ready=1 and flush=0.
REQ-016 enq_ready SHALL equal (count != DEPTH), registered or derived from state only, with no combinational path from deq_ready or enq_valid.
REQ-017 deq_valid SHALL equal (count != 0) and SHALL depend on state only.
REQ-018 deq_data SHALL be first-word-fall-through: the head entry is visible in the cycle after it is written, with one cycle of enqueue-to-dequeue latency.
REQ-019 deq_data SHALL be all zeros whenever count = 0, so an empty queue presents a NOP bubble.
REQ-020 Entries SHALL leave in strict FIFO order, with no reordering or duplication.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 without an extra cycle.
REQ-022 A simultaneous enqueue and dequeue SHALL leave count unchanged; this includes count = 1, where the new entry becomes the head next cycle.
REQ-023 When count = DEPTH, enq_ready SHALL be 0, enq_valid SHALL be ignored, and stored data SHALL NOT be overwritten, even if a dequeue occurs in the same cycle.
REQ-024 When count = 0, deq_ready SHALL be ignored and count SHALL NOT underflow.
REQ-025 flush=1 SHALL, at the next edge, set count to 0, set both pointers to 0 and zero deq_data.
REQ-026 flush SHALL have priority over any concurrent enqueue or dequeue, which are both discarded.
REQ-027 When no enqueue, dequeue or flush occurs, all state SHALL hold its value (stall).
REQ-028 count SHALL change only at rising edges: +1 on enqueue only, -1 on dequeue only, and unchanged otherwise.

Reset
REQ-029 While nRST=0, the following SHALL hold immediately, without waiting for a clock: count=0, deq_valid=0, deq_data=0, enq_ready=1, and pointers=0.
REQ-030 Assertion of nRST during operation SHALL discard all entries exactly as flush does.
REQ-031 Deassertion of nRST SHALL allow an enqueue on the first following rising edge.

Verification (DEPTH=4, DATA_W=96)
REQ-032 Fill/drain: enqueue A,B,C,D with deq_ready=0 -> count=4 and enq_ready=0; then deq_ready=1 for 4 cycles -> deq_data=A,B,C,D in order, ending with count=0 and deq_data=0.
REQ-033 Full with simultaneous traffic: at count=4, enq_valid=1 (E) and deq_ready=1 -> A leaves, E is rejected, count=3, and E never appears on deq_data.
REQ-034 Steady stream: enq_valid=1 and deq_ready=1 continuously for 10 entries, starting empty -> count stays 1 after the first edge, every entry emerges one cycle after enqueue, and pointers wrap twice.
REQ-035 Flush collision: at count=3, flush=1 with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, deq_data=0, and the offered entry is dropped.
REQ-036 Mid-operation reset: at count=2, drive nRST=0 between clock edges -> outputs take reset values immediately; after release, the first enqueue X appears as the head with count=1.
REQ-037 Empty underflow: deq_ready=1 for 3 cycles while empty -> count stays 0, deq_valid stays 0, and deq_data stays 0.
